// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared load/store size codes and responder FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lsu_align
// Description : Byte-lane store merge, load extension and alignment fault check.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lsu_align
    import mem_pkg::*;
(
    input  logic        i_write,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_old_word,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata,
    output logic        o_fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_old_word[{i_addr, 3'b000} +: 8];
    assign w_half = i_old_word[{i_addr[1], 4'b0000} +: 16];

    always_comb begin
        o_wword = i_old_word;
        o_rdata = 32'h0;
        o_fault = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_rdata = {{24{w_byte[7]}}, w_byte};
                o_wword[{i_addr, 3'b000} +: 8] = i_wdata[7:0];
            end
            F3_H: begin
                o_fault = i_addr[0];
                o_rdata = {{16{w_half[15]}}, w_half};
                o_wword[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            F3_W: begin
                o_fault = (i_addr != 2'b00);
                o_rdata = i_old_word;
                o_wword = i_wdata;
            end
            // Unsigned sizes exist only for loads; a store using them faults.
            F3_BU: begin
                o_fault = i_write;
                o_rdata = {24'h0, w_byte};
            end
            F3_HU: begin
                o_fault = i_write | i_addr[0];
                o_rdata = {16'h0, w_half};
            end
            default: o_fault = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Multi-cycle data memory servicing M-stage loads/stores with stall.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemStallM,
    output logic        MisalignM
);

    localparam int         c_AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_LAT = 4'(LATENCY);

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic           r_write;
    logic [2:0]     r_funct3;
    logic [c_AW+1:0] r_addr;
    logic [31:0]    r_wdata;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_op_write;
    logic [2:0]     w_op_funct3;
    logic [c_AW+1:0] w_op_addr;
    logic [31:0]    w_op_wdata;
    logic [c_AW-1:0] w_idx;
    logic [31:0]    w_old_word;
    logic [31:0]    w_wword;
    logic [31:0]    w_rdata;
    logic           w_fault;
    logic           w_enter_resp;
    logic           w_unused_addr;

    // With zero wait states the access completes straight out of IDLE, so the
    // datapath must see the live inputs rather than the not-yet-latched copies.
    assign w_op_write  = (r_state == IDLE) ? MemWriteM  : r_write;
    assign w_op_funct3 = (r_state == IDLE) ? Funct3M    : r_funct3;
    assign w_op_addr   = (r_state == IDLE) ? ALUResultM[c_AW+1:0] : r_addr;
    assign w_op_wdata  = (r_state == IDLE) ? WriteDataM : r_wdata;

    assign w_idx         = w_op_addr[c_AW+1:2];
    assign w_old_word    = r_mem[w_idx];
    assign w_unused_addr = &{1'b0, ALUResultM[31:c_AW+2]};

    assign w_enter_resp = ((r_state == IDLE) && MemReqM && (LATENCY == 0)) ||
                          ((r_state == WAIT) && (r_cnt == 4'd1));

    assign MemStallM = ((r_state == IDLE) && MemReqM) || (r_state == WAIT);

    dmem_lsu_align u_align (
        .i_write    (w_op_write),
        .i_funct3   (w_op_funct3),
        .i_addr     (w_op_addr[1:0]),
        .i_wdata    (w_op_wdata),
        .i_old_word (w_old_word),
        .o_wword    (w_wword),
        .o_rdata    (w_rdata),
        .o_fault    (w_fault)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_write   <= 1'b0;
            r_funct3  <= 3'd0;
            r_addr    <= '0;
            r_wdata   <= 32'h0;
            ReadDataM <= 32'h0;
            MisalignM <= 1'b0;
        end else begin
            MisalignM <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (MemReqM) begin
                        r_write  <= MemWriteM;
                        r_funct3 <= Funct3M;
                        r_addr   <= ALUResultM[c_AW+1:0];
                        r_wdata  <= WriteDataM;
                        r_cnt    <= c_LAT;
                        r_state  <= (LATENCY > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_enter_resp) begin
                if (w_fault) begin
                    ReadDataM <= 32'h0;
                    MisalignM <= 1'b1;
                end else if (!w_op_write) begin
                    ReadDataM <= w_rdata;
                end
            end
        end
    end

    // Storage is never cleared; a reset only suppresses an in-flight commit.
    always_ff @(posedge clk) begin
        if (!reset && w_enter_resp && w_op_write && !w_fault) begin
            r_mem[w_idx] <= w_wword;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder at LATENCY 2 and LATENCY 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    import mem_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        req   = 1'b0;
    logic        sel   = 1'b0;
    logic        wr    = 1'b0;
    logic [2:0]  f3    = 3'd0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic        req_a, req_b;
    logic [31:0] rd_a, rd_b;
    logic        stall_a, stall_b, mis_a, mis_b;

    assign req_a = req & ~sel;
    assign req_b = req & sel;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .MemReqM(req_a), .MemWriteM(wr), .Funct3M(f3),
        .ALUResultM(addr), .WriteDataM(wdata), .ReadDataM(rd_a),
        .MemStallM(stall_a), .MisalignM(mis_a)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .MemReqM(req_b), .MemWriteM(wr), .Funct3M(f3),
        .ALUResultM(addr), .WriteDataM(wdata), .ReadDataM(rd_b),
        .MemStallM(stall_b), .MisalignM(mis_b)
    );

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        int          stall;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rd_a = 32'h0;
    logic [31:0] last_rd_b = 32'h0;

    // One access; expectation is queued at issue and retired on the response cycle.
    task automatic access(input bit s, input bit w, input logic [2:0] fn,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_load, input bit flt, input bit scramble);
        exp_t        e;
        exp_t        got;
        int          n;
        bit          early_mis;
        logic [31:0] prev;
        prev  = s ? last_rd_b : last_rd_a;
        e.rd  = flt ? 32'h0 : (w ? prev : exp_load);
        e.mis = flt;
        e.stall = s ? 1 : 3;
        if (s) last_rd_b = e.rd; else last_rd_a = e.rd;
        sb_q.push_back(e);
        sel = s; wr = w; f3 = fn; addr = a; wdata = d; req = 1'b1;
        n = 0;
        early_mis = 1'b0;
        forever begin
            @(negedge clk);
            if ((s ? stall_b : stall_a) === 1'b1) begin
                n++;
                if ((s ? mis_b : mis_a) !== 1'b0) early_mis = 1'b1;
                if (scramble && n >= 2) begin
                    req = 1'b0; wr = ~w; f3 = 3'($urandom);
                    addr = $urandom; wdata = $urandom;
                end
                if (n > 40) break;
            end else begin
                break;
            end
        end
        got = sb_q.pop_front();
        checks++;
        if (n !== got.stall) begin
            errors++;
            $display("FAIL stall_cycles @%h: got %0d expected %0d", a, n, got.stall);
        end
        checks++;
        if ((s ? rd_b : rd_a) !== got.rd) begin
            errors++;
            $display("FAIL read_data @%h: got %h expected %h", a, s ? rd_b : rd_a, got.rd);
        end
        checks++;
        if ((s ? mis_b : mis_a) !== got.mis) begin
            errors++;
            $display("FAIL misalign_resp @%h: got %b expected %b", a, s ? mis_b : mis_a, got.mis);
        end
        checks++;
        if (early_mis !== 1'b0) begin
            errors++;
            $display("FAIL misalign_early @%h: got %b expected 0", a, early_mis);
        end
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_a !== 32'h0 || rd_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h expected 0/0", rd_a, rd_b);
        end
        checks++;
        if (mis_a !== 1'b0 || stall_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got mis=%b stall=%b expected 0/0", mis_a, stall_a);
        end
        sel = 1'b0; req = 1'b1;
        #1;
        checks++;
        if (stall_a !== 1'b1) begin
            errors++;
            $display("FAIL idle_stall_follows_req: got %b expected 1", stall_a);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_word;
        access(0, 1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        access(0, 0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    endtask

    task automatic test_subword_load;
        access(0, 1, F3_W,  32'h20, 32'h80402010, 32'h0, 0, 0);
        access(0, 0, F3_B,  32'h23, 32'h0, 32'hFFFFFF80, 0, 0);
        access(0, 0, F3_BU, 32'h23, 32'h0, 32'h00000080, 0, 0);
        access(0, 0, F3_H,  32'h22, 32'h0, 32'hFFFF8040, 0, 0);
        access(0, 0, F3_HU, 32'h20, 32'h0, 32'h00002010, 0, 0);
        access(0, 0, F3_B,  32'h21, 32'h0, 32'h00000020, 0, 0);
    endtask

    task automatic test_store_merge;
        access(0, 1, F3_W, 32'h20, 32'h11223344, 32'h0, 0, 0);
        access(0, 1, F3_B, 32'h21, 32'hFFFFFFAA, 32'h0, 0, 0);
        access(0, 0, F3_W, 32'h20, 32'h0, 32'h1122AA44, 0, 0);
        access(0, 1, F3_H, 32'h22, 32'h12345566, 32'h0, 0, 0);
        access(0, 0, F3_W, 32'h20, 32'h0, 32'h5566AA44, 0, 0);
    endtask

    task automatic test_faults;
        access(0, 0, F3_W, 32'h22, 32'h0, 32'h0, 1, 0);
        checks++;
        if (mis_a !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse_width: got %b expected 0", mis_a);
        end
        access(0, 1, F3_H,   32'h21, 32'hFFFFFFFF, 32'h0, 1, 0);
        access(0, 1, F3_BU,  32'h20, 32'h00000000, 32'h0, 1, 0);
        access(0, 0, F3_W,   32'h20, 32'h0, 32'h5566AA44, 0, 0);
        access(0, 0, 3'b011, 32'h20, 32'h0, 32'h0, 1, 0);
        access(0, 0, F3_HU,  32'h23, 32'h0, 32'h0, 1, 0);
    endtask

    task automatic test_input_hold;
        access(0, 0, F3_W, 32'h20, 32'h0, 32'h5566AA44, 0, 1);
        access(0, 1, F3_W, 32'h24, 32'h0BADCAFE, 32'h0, 0, 1);
        access(0, 0, F3_W, 32'h24, 32'h0, 32'h0BADCAFE, 0, 0);
    endtask

    task automatic test_back_to_back;
        access(0, 0, F3_HU, 32'h22, 32'h0, 32'h00005566, 0, 0);
        access(0, 0, F3_BU, 32'h21, 32'h0, 32'h000000AA, 0, 0);
        access(0, 0, F3_B,  32'h21, 32'h0, 32'hFFFFFFAA, 0, 0);
    endtask

    task automatic test_latency0;
        access(1, 1, F3_W,  (DEPTH * 4) + 4, 32'h600DD00D, 32'h0, 0, 0);
        access(1, 0, F3_W,  32'h4, 32'h0, 32'h600DD00D, 0, 0);
        access(1, 1, F3_B,  32'h5, 32'h00000077, 32'h0, 0, 0);
        access(1, 0, F3_W,  32'h4, 32'h0, 32'h600D770D, 0, 0);
        access(1, 0, F3_W,  32'h6, 32'h0, 32'h0, 1, 0);
        access(1, 0, F3_BU, 32'h7, 32'h0, 32'h00000060, 0, 0);
    endtask

    task automatic test_reset_mid;
        access(0, 1, F3_W, 32'h30, 32'hCAFEF00D, 32'h0, 0, 0);
        sel = 1'b0; wr = 1'b1; f3 = F3_W; addr = 32'h30; wdata = 32'hBAD0BAD0; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        checks++;
        if (stall_a !== 1'b1) begin
            errors++;
            $display("FAIL wait_stall_after_req_drop: got %b expected 1", stall_a);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_a !== 1'b0 || mis_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: got stall=%b mis=%b expected 0/0", stall_a, mis_a);
        end
        checks++;
        if (rd_a !== 32'h0) begin
            errors++;
            $display("FAIL midreset_rdata: got %h expected 00000000", rd_a);
        end
        last_rd_a = 32'h0;
        last_rd_b = 32'h0;
        @(posedge clk);
        #1;
        access(0, 0, F3_W, 32'h30, 32'h0, 32'hCAFEF00D, 0, 0);
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_load();
        test_store_merge();
        test_faults();
        test_input_hold();
        test_back_to_back();
        test_latency0();
        test_reset_mid();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the pipeline's memory-stage interface.
- Accepts load/store requests from the M stage and services them from an internal word-organised RAM after a fixed number of wait states.
- Returns sign/zero-extended load data and holds the pipeline through a stall request until the access completes.
- Replaces the zero-latency data memory so that multi-cycle backing storage can be modelled.

Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words; must be a power of two.
- LATENCY, 2: wait states between accept and response; 0..15 legal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- MemReqM  in  1  access request from M stage (load or store)
- MemWriteM  in  1  1 = store, 0 = load; qualified by MemReqM
- Funct3M  in  3  RV32I size/sign code of the M-stage instruction
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, right-aligned
- ReadDataM  out  32  extended load data; registered
- MemStallM  out  1  stall request to hazard unit
- MisalignM  out  1  one-cycle error pulse on a faulting access

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - FSM returns to IDLE.
  - ReadDataM = 0, MisalignM = 0, wait counter = 0.
  - MemStallM = 0 once reset is sampled.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - MemReqM=1: latch MemWriteM, Funct3M, ALUResultM and WriteDataM; load counter with LATENCY.
  - Next state is WAIT if LATENCY>0, otherwise RESP.
- WAIT: decrement the counter each cycle; go to RESP on the cycle the counter reads 1.
- RESP: lasts exactly one cycle, then IDLE.
- MemStallM (combinational) = (IDLE & MemReqM) | WAIT. It is 0 in RESP, so the M stage advances at the end of RESP.
- Latency:
  - A request first seen in cycle t completes in cycle t+LATENCY+1.
  - MemStallM is high for LATENCY+1 cycles.
- A following request needs a new IDLE cycle, so back-to-back accesses cost LATENCY+2 cycles each.
- After accept, all work uses latched values. Changes on the inputs, including MemReqM dropping, are ignored until back in IDLE.
- Load data:
  - Registered on the edge entering RESP; valid throughout RESP.
  - Held unchanged until the next load completes.
  - Stores do not modify ReadDataM.
- Loads, by Funct3M:
  - 000 lb: byte at addr[1:0], sign-extended.
  - 001 lh: halfword at addr[1], sign-extended.
  - 010 lw: full word.
  - 100 lbu: byte, zero-extended.
  - 101 lhu: halfword, zero-extended.
- Stores, by Funct3M: 000 sb, 001 sh, 010 sw.
  - Byte-lane merge; unaddressed bytes are preserved.
  - The RAM write commits on the edge entering RESP.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap.
- Faults:
  - Halfword with addr[0]=1, word with addr[1:0]!=0, or any other Funct3M code (including 1xx on a store).
  - On a fault: no RAM write, ReadDataM loaded with 0, MisalignM=1 for the RESP cycle only.
  - The access still takes the normal latency.
- Reset mid-operation:
  - Abandon the access; no RAM write occurs.
  - Next cycle is IDLE with MemStallM following MemReqM.

Decomposition:
- Shared package mem_pkg:
  - Funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State enum {IDLE, WAIT, RESP}.
- One natural combinational sub-module, dmem_lsu_align:
  - Inputs: funct3, addr[1:0], write data, old word.
  - Outputs: merged write word, extended load data, fault flag.
- The FSM, counter and RAM array stay in dmem_responder.

Test Plan:
1. LATENCY=2; store sw, addr 0x10, data 0xDEADBEEF; then lw, addr 0x10.
   - Stall high 3 cycles per access.
   - Load's RESP cycle shows ReadDataM=0xDEADBEEF.
   - MisalignM=0.
2. Sub-word loads over word 0x80402010 at 0x20:
   - lb 0x23 -> 0x00000080? no, byte3=0x80 -> 0xFFFFFF80.
   - lbu 0x23 -> 0x00000080.
   - lh 0x22 -> 0xFFFF8040.
   - lhu 0x20 -> 0x00002010.
3. sb 0xAA to 0x21 over 0x11223344, then lw 0x20 -> 0x1122AA44. sh 0x5566 to 0x22, then lw -> 0x5566AA44.
4. Faults:
   - lw at 0x22 -> MisalignM pulse in RESP, ReadDataM=0.
   - sh at 0x21 -> word unchanged on read-back.
   - Funct3M=011 load -> fault.
5. LATENCY=0: stall exactly 1 cycle per access. Wrap: sw to (DEPTH_WORDS*4)+4 reads back at address 4.
6. Reset asserted during WAIT of an sw to 0x30:
   - Next cycle state IDLE, ReadDataM=0.
   - A later lw 0x30 returns the pre-reset contents.
